gpio_input_debounce: RTL
========================

// Module: gpio_input_debounce
// PURPOSE
//  Conditions raw board inputs (DIPSW) before they reach the GPIO read path as GPI.
//  Per-bit pipeline: 2-FF synchronizer -> debounce counter -> stable value.
//  Also keeps sticky rising/falling change flags and raises a maskable IRQ.
//  Sits directly upstream of the GPIO read port; the CPU reads GPI and the flags via RD_GPIO.
// PARAMETERS
//  WIDTH            4   number of input bits
//  DEBOUNCE_CYCLES  16  consecutive stable clocks required to accept a new level (>=2)
//  CNT_W            5   debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  CLK         in   1      system clock; all state updates on rising edge
//  RESET       in   1      asynchronous, active-high reset
//  PIN_IN      in   WIDTH  raw asynchronous inputs (DIPSW)
//  RD_GPIO     in   1      read strobe; clears change flags on the clock edge where it is high
//  WR_MASK     in   1      write strobe; loads IRQ mask from DIN
//  DIN         in   WIDTH  mask write data
//  GPI         out  WIDTH  debounced input value
//  RISE_FLAGS  out  WIDTH  sticky: bit went 0->1 on GPI since last clear
//  FALL_FLAGS  out  WIDTH  sticky: bit went 1->0 on GPI since last clear
//  IRQ         out  1      |((RISE_FLAGS|FALL_FLAGS) & mask)
// BEHAVIOUR
//  Reset (async, RESET=1): sync regs, GPI, counters, flags, mask = 0; IRQ = 0.
//  Synchronizer: s1<=PIN_IN; s2<=s1. Metastability only on s1; s2 feeds all logic.
//  Debounce, per bit i, independent:
//   - s2[i]==GPI[i]: cnt[i]<=0.
//   - s2[i]!=GPI[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
//   - s2[i]!=GPI[i] and cnt[i]==DEBOUNCE_CYCLES-1: GPI[i]<=s2[i]; cnt[i]<=0.
//   - Any return of s2[i] to GPI[i] before acceptance restarts the count (glitch rejected).
//   - Counter never wraps; it saturates at DEBOUNCE_CYCLES-1 by construction.
//  Latency: PIN_IN step held steady before edge N -> GPI updates at edge N+DEBOUNCE_CYCLES+1.
//   Equivalently, visible DEBOUNCE_CYCLES+2 rising edges after the input changes.
//  Change flags (set in the same edge GPI[i] updates):
//   - Rising: RISE_FLAGS[i]<=1 when GPI[i] 0->1.
//   - Falling: FALL_FLAGS[i]<=1 when GPI[i] 1->0.
//   - RD_GPIO=1 at an edge clears all flags.
//   - Set and clear in the same edge: set wins (the event is never lost).
//   - Both flags may be 1 simultaneously (the bit toggled twice before a read).
//  Mask: WR_MASK=1 at an edge -> mask<=DIN. Mask does not alter the flags.
//  IRQ: combinational from flag and mask registers; no extra latency.
//   - Drops the edge after RD_GPIO clears the flags, or when the mask is zeroed.
//  RD_GPIO and WR_MASK in the same cycle are independent; both take effect.
//  RESET mid-debounce: the count is discarded, GPI returns to 0.
//   - After release, a held-high input is re-accepted after the full latency and sets RISE_FLAGS.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 Reset: RESET=1, PIN_IN=4'b1111 -> GPI=0, flags=0, IRQ=0 throughout reset.
//  2 Latency: release reset, PIN_IN=4'b0000 -> 4'b0001 before edge N
//     -> GPI=4'b0001 at edge N+5 (not N+4); RISE_FLAGS=4'b0001.
//  3 Glitch: PIN_IN[1] high for 3 clocks, then low -> GPI[1] stays 0; no flag set.
//  4 IRQ/mask: WR_MASK, DIN=4'b0100; debounce PIN_IN[2] 0->1 -> IRQ=1.
//     Then debounce PIN_IN[3] 0->1 with mask bit 3 clear -> RISE_FLAGS[3]=1, IRQ unchanged.
//  5 Clear/set race: pulse RD_GPIO on the same edge that GPI[0] falls
//     -> FALL_FLAGS=4'b0001, all other flags 0; IRQ follows mask.
//  6 Reset mid-count: assert RESET 2 clocks into a PIN_IN[0] debounce, release
//     -> GPI[0]=0, then 1 exactly 6 edges after release; RISE_FLAGS[0]=1.

Source files
------------

// File: rtl/gpio_input_debounce.sv
// Conditions raw board inputs: 2-FF synchronizer, per-bit debounce,
// sticky rise/fall change flags and a maskable interrupt.
module gpio_input_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PIN_IN,
    input  logic             RD_GPIO,
    input  logic             WR_MASK,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] GPI,
    output logic [WIDTH-1:0] RISE_FLAGS,
    output logic [WIDTH-1:0] FALL_FLAGS,
    output logic             IRQ
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] gpi_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] accept;
    logic [CNT_W-1:0] cnt [WIDTH];

    // A bit is accepted on the edge that would complete its stable run.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != gpi_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1     <= '0;
            s2     <= '0;
            gpi_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            mask_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= PIN_IN;
            s2 <= s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == gpi_q[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            gpi_q <= gpi_q ^ accept;
            // New events OR in after the read clear so none is lost.
            rise_q <= (RD_GPIO ? '0 : rise_q) | (accept & s2);
            fall_q <= (RD_GPIO ? '0 : fall_q) | (accept & ~s2);
            if (WR_MASK) begin
                mask_q <= DIN;
            end
        end
    end

    assign GPI        = gpi_q;
    assign RISE_FLAGS = rise_q;
    assign FALL_FLAGS = fall_q;
    assign IRQ        = |((rise_q | fall_q) & mask_q);

endmodule
